regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline WB result and an auxiliary long-latency unit (multi-cycle divider/CSR unit).
- The pipeline has priority; auxiliary results are buffered in a small FIFO and drained in idle WB cycles.
- A starvation counter forces a one-cycle pipeline stall so the FIFO drains.
- Scoreboard outputs flag ID-stage reads of registers whose writes are still queued.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, auxiliary result entries (power of two, >=2).
- STARVE_MAX, 4, consecutive pipeline-won cycles with the FIFO non-empty before a forced drain.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- RegWriteW  in  1  pipeline WB write enable.
- rdW  in  5  pipeline WB destination.
- ResultW  in  XLEN  pipeline WB data.
- aux_valid  in  1  auxiliary result offered.
- aux_ready  out  1  auxiliary result accepted this cycle when aux_valid=1.
- aux_rd  in  5  auxiliary destination.
- aux_data  in  XLEN  auxiliary data.
- rs1D  in  5  ID-stage source 1.
- rs2D  in  5  ID-stage source 2.
- pend_hazard  out  1  rs1D or rs2D (non-zero) matches a queued FIFO rd.
- stall_req  out  1  pipeline must hold WB and upstream registers this cycle.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset (asynchronous) empties the FIFO and clears starve_cnt and all pointers. While reset is asserted: rf_we=0, rf_rd=0, rf_wdata=0, stall_req=0, pend_hazard=0, aux_ready=0.
- Write-port outputs are combinational from registered state and the current pipeline inputs. A write takes effect at the next clk edge inside the register file.
- Definitions: pipe_wr = RegWriteW && rdW!=0. force = (starve_cnt==STARVE_MAX) && !empty.
- Priority, evaluated each cycle:
  1. force: write FIFO head; stall_req=1; pop. The pipeline WB write is not performed this cycle; the pipeline re-presents it next cycle.
  2. else pipe_wr: write rdW/ResultW. If !empty, starve_cnt increments, saturating at STARVE_MAX.
  3. else !empty: write FIFO head; pop.
  4. else rf_we=0.
- starve_cnt clears on every pop and whenever the FIFO is empty.
- A pipeline write with rdW=0 is never driven to the port and does not count as a pipeline win.
- aux_ready = !full || pop_this_cycle. Enqueue and pop in the same cycle are legal when full.
- An auxiliary result with aux_rd=0 is accepted (aux_ready obeys the rule above) but not stored.
- An enqueue into an empty FIFO is not writable in the same cycle; earliest write is the next cycle (1-cycle minimum latency).
- FIFO order is strict; pointers wrap modulo FIFO_DEPTH with an extra bit distinguishing full from empty.
- pend_hazard compares rs1D/rs2D against all valid FIFO entries and the entry being enqueued this cycle. rs=0 never matches. An entry popped this cycle still counts as matching.
- stall_req is asserted only in case 1, for exactly one cycle per forced pop. Repeated forcing needs STARVE_MAX new pipeline wins.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- Defined: adds outputs stat_stall_cycles [31:0] (counts stall_req cycles) and stat_aux_writes [31:0] (counts pops that wrote the port). Both counters wrap, and both clear on reset.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package regfile_arb_pkg holds:
  - XLEN and REG_ADDR_W=5 constants;
  - aux_entry_t struct {rd[4:0], data[XLEN-1:0]};
  - the arbitration-source enum {SRC_NONE, SRC_PIPE, SRC_AUX}.
- One sub-module, aux_result_fifo: FIFO storage, pointers, full/empty flags, and per-entry rd outputs used for the hazard compare.

Test Plan:
1. Reset mid-operation: FIFO holds 2 entries and reset is asserted → outputs are 0 immediately. After release, empty=1, no writes, aux_ready=1.
2. Idle drain: aux_valid with rd=5, data=0x1234, no pipeline writes → next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234, aux_ready stays 1.
3. Priority/starvation: FIFO holds rd=7, and RegWriteW=1 with rdW=3 every cycle → 4 cycles of pipeline writes to x3. The 5th cycle writes x7 with stall_req=1. The 6th cycle writes x3 again.
4. Full backpressure: 2 entries queued and pipeline busy → aux_ready=0. On the forced pop cycle aux_ready=1, and the new entry is enqueued the same cycle.
5. x0 handling: aux_rd=0 accepted → never written, FIFO stays empty. RegWriteW=1 with rdW=0 → rf_we=0 and no starve increment.
6. Hazard: FIFO holds rd=9, rs1D=9 → pend_hazard=1. rs2D=0 with an entry rd=0 (dropped) → 0. After the pop cycle, pend_hazard returns to 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared constants, types and helpers for the register-file write arbiter
package regfile_arb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } aux_entry_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_AUX} arb_src_t;

    // x0 is never a real destination, so it can never create a hazard
    function automatic logic rdMatches(
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return rd != '0 && (rd == rs1 || rd == rs2);
    endfunction
endpackage

// File: rtl/aux_result_fifo.sv
// aux_result_fifo: in-order buffer of auxiliary-unit results with per-slot rd/valid views
module aux_result_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  aux_entry_t            pushEntry,
    input  logic                  pop,
    output aux_entry_t            head,
    output logic                  empty,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] entryRd [DEPTH],
    output logic [DEPTH-1:0]      entryValid
);
    localparam int AW = $clog2(DEPTH);

    aux_entry_t    mem [DEPTH];
    logic [AW:0]   wrPtr, rdPtr, count;

    assign count = wrPtr - rdPtr;
    assign empty = wrPtr == rdPtr;
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= pushEntry;
    end

    // a slot is live when its distance from the read pointer is below the fill count
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [AW-1:0] off;
        assign off           = AW'(i) - rdPtr[AW-1:0];
        assign entryRd[i]    = mem[i].rd;
        assign entryValid[i] = {1'b0, off} < count;
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the RF write port between pipeline WB and a buffered aux unit
// Optional statistics counters enabled by REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            aux_valid,
    output logic            aux_ready,
    input  logic [4:0]      aux_rd,
    input  logic [XLEN-1:0] aux_data,
    input  logic [4:0]      rs1D,
    input  logic [4:0]      rs2D,
    output logic            pend_hazard,
    output logic            stall_req,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
`ifdef REGFILE_ARB_STATS_EN
    ,output logic [31:0]    stat_stall_cycles,
    output logic [31:0]     stat_aux_writes
`endif
);
    import regfile_arb_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);

    aux_entry_t      head;
    logic            empty, full, push, pop, pipeWr, forceDrain;
    logic [4:0]      entryRd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entryValid;
    logic [CW-1:0]   starveCnt;
    arb_src_t        src;

    aux_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pushEntry  ('{rd: aux_rd, data: aux_data}),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .entryRd    (entryRd),
        .entryValid (entryValid)
    );

    // gating with reset keeps every output quiet while reset is held
    assign pipeWr     = !reset && RegWriteW && rdW != '0;
    assign forceDrain = starveCnt == CW'(STARVE_MAX) && !empty;
    assign src        = forceDrain ? SRC_AUX : pipeWr ? SRC_PIPE : !empty ? SRC_AUX : SRC_NONE;
    assign pop        = src == SRC_AUX;
    assign stall_req  = forceDrain;
    assign aux_ready  = !reset && (!full || pop);
    assign push       = aux_valid && aux_ready && aux_rd != '0;
    assign rf_we      = src != SRC_NONE;
    assign rf_rd      = src == SRC_PIPE ? rdW : src == SRC_AUX ? head.rd : '0;
    assign rf_wdata   = src == SRC_PIPE ? ResultW : src == SRC_AUX ? head.data : '0;

    always_comb begin
        pend_hazard = push && rdMatches(aux_rd, rs1D, rs2D);
        for (int i = 0; i < FIFO_DEPTH; i++)
            pend_hazard |= entryValid[i] && rdMatches(entryRd[i], rs1D, rs2D);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starveCnt <= '0;
        else if (pop || empty) starveCnt <= '0;
        else if (pipeWr && starveCnt != CW'(STARVE_MAX)) starveCnt <= starveCnt + 1'b1;
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall_cycles <= '0;
            stat_aux_writes   <= '0;
        end else begin
            if (stall_req) stat_stall_cycles <= stat_stall_cycles + 1'b1;
            if (pop) stat_aux_writes <= stat_aux_writes + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: queue-model checker plus directed literal checks for the write arbiter
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 0, reset = 1;
    logic        RegWriteW = 0, aux_valid = 0;
    logic [4:0]  rdW = 0, aux_rd = 0, rs1D = 0, rs2D = 0;
    logic [31:0] ResultW = 0, aux_data = 0;
    logic        aux_ready, pend_hazard, stall_req, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef REGFILE_ARB_STATS_EN
    logic [31:0] stat_stall_cycles, stat_aux_writes;
`endif

    regfile_wr_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
        .rs1D(rs1D), .rs2D(rs2D), .pend_hazard(pend_hazard), .stall_req(stall_req),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef REGFILE_ARB_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_aux_writes(stat_aux_writes)
`endif
    );

    always #5 clk = ~clk;

    int passCnt = 0, total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        else passCnt++;
    endtask

    typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
    ent_t q[$];
    int   starve = 0;

    // reference model: queue of pending aux results and a starvation count
    always @(negedge clk) begin
        automatic logic pw, frc, pop, rdy, hz, we, st, enq, wasEmpty;
        automatic logic [4:0] erd;
        automatic logic [31:0] ed;
        if (reset) begin
            q.delete();
            starve = 0;
            chk("m_rf_we", rf_we, 0);
            chk("m_rf_rd", rf_rd, 0);
            chk("m_rf_wdata", rf_wdata, 0);
            chk("m_stall", stall_req, 0);
            chk("m_ready", aux_ready, 0);
            chk("m_hazard", pend_hazard, 0);
        end else begin
            pw = RegWriteW && rdW != 0;
            frc = starve == SMAX && q.size() > 0;
            we = 0; erd = 0; ed = 0; st = 0; pop = 0;
            if (frc) begin we = 1; erd = q[0].rd; ed = q[0].d; st = 1; pop = 1; end
            else if (pw) begin we = 1; erd = rdW; ed = ResultW; end
            else if (q.size() > 0) begin we = 1; erd = q[0].rd; ed = q[0].d; pop = 1; end
            rdy = q.size() < DEPTH || pop;
            enq = aux_valid && rdy && aux_rd != 0;
            hz = 0;
            foreach (q[i])
                if (q[i].rd != 0 && (q[i].rd == rs1D || q[i].rd == rs2D)) hz = 1;
            if (enq && (aux_rd == rs1D || aux_rd == rs2D)) hz = 1;
            chk("m_rf_we", rf_we, we);
            chk("m_rf_rd", rf_rd, erd);
            chk("m_rf_wdata", rf_wdata, ed);
            chk("m_stall", stall_req, st);
            chk("m_ready", aux_ready, rdy);
            chk("m_hazard", pend_hazard, hz);
            wasEmpty = q.size() == 0;
            if (pop) void'(q.pop_front());
            if (enq) q.push_back('{aux_rd, aux_data});
            if (pop || wasEmpty) starve = 0;
            else if (pw && starve < SMAX) starve++;
        end
    end

    task automatic step(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        RegWriteW = rw; rdW = rd; ResultW = res;
        aux_valid = av; aux_rd = ard; aux_data = ad;
        rs1D = r1; rs2D = r2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        // reset in the middle of a full FIFO
        step(1, 2, 'h22, 1, 1, 'h11, 0, 0);
        #2 chk("t1_pipe_rd", rf_rd, 2);
        step(1, 2, 'h22, 1, 4, 'h44, 0, 0);
        step(1, 2, 'h22, 0, 0, 0, 1, 0);
        #2 chk("t1_full_ready", aux_ready, 0);
        chk("t1_hazard", pend_hazard, 1);
        reset = 1;
        #1 chk("t1_rst_we", rf_we, 0);
        chk("t1_rst_rd", rf_rd, 0);
        chk("t1_rst_ready", aux_ready, 0);
        chk("t1_rst_hazard", pend_hazard, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        reset = 0;
        #2 chk("t1_post_we", rf_we, 0);
        chk("t1_post_ready", aux_ready, 1);
        chk("t1_post_hazard", pend_hazard, 0);
        // idle drain
        step(0, 0, 0, 1, 5, 'h1234, 0, 0);
        #2 chk("t2_enq_we", rf_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t2_we", rf_we, 1);
        chk("t2_rd", rf_rd, 5);
        chk("t2_data", rf_wdata, 'h1234);
        chk("t2_ready", aux_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t2_idle_we", rf_we, 0);
        // starvation forces a drain after four pipeline wins
        step(0, 0, 0, 1, 7, 'h77, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 3, 'h33, 0, 0, 0, 0, 0);
            #2 chk("t3_pipe_rd", rf_rd, 3);
            chk("t3_pipe_stall", stall_req, 0);
        end
        step(1, 3, 'h33, 0, 0, 0, 0, 0);
        #2 chk("t3_force_rd", rf_rd, 7);
        chk("t3_force_data", rf_wdata, 'h77);
        chk("t3_force_stall", stall_req, 1);
        step(1, 3, 'h33, 0, 0, 0, 0, 0);
        #2 chk("t3_after_rd", rf_rd, 3);
        chk("t3_after_stall", stall_req, 0);
        // full backpressure released by the forced pop
        step(1, 3, 'h33, 1, 8, 'h88, 0, 0);
        step(1, 3, 'h33, 1, 9, 'h99, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 'h33, 1, 10, 'haa, 0, 0);
            #2 chk("t4_bp_ready", aux_ready, 0);
        end
        step(1, 3, 'h33, 1, 10, 'haa, 0, 0);
        #2 chk("t4_force_stall", stall_req, 1);
        chk("t4_force_rd", rf_rd, 8);
        chk("t4_force_ready", aux_ready, 1);
        step(1, 3, 'h33, 0, 0, 0, 0, 0);
        #2 chk("t4_pipe_rd", rf_rd, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t4_drain1", rf_rd, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t4_drain2", rf_rd, 10);
        chk("t4_drain2_data", rf_wdata, 'haa);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t4_empty_we", rf_we, 0);
        // x0 destinations
        step(0, 0, 0, 1, 0, 'hdead, 0, 0);
        #2 chk("t5_x0_ready", aux_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t5_x0_we", rf_we, 0);
        step(1, 0, 'h55, 1, 11, 'hbb, 0, 0);
        #2 chk("t5_rd0_we", rf_we, 0);
        step(1, 0, 'h55, 0, 0, 0, 0, 0);
        #2 chk("t5_drain_rd", rf_rd, 11);
        chk("t5_drain_stall", stall_req, 0);
        // hazard tracking
        step(1, 3, 'h33, 1, 9, 'h99, 9, 0);
        #2 chk("t6_enq_hz", pend_hazard, 1);
        step(1, 3, 'h33, 0, 0, 0, 0, 9);
        #2 chk("t6_rs2_hz", pend_hazard, 1);
        step(1, 3, 'h33, 1, 0, 0, 0, 0);
        #2 chk("t6_x0_hz", pend_hazard, 0);
        step(0, 0, 0, 0, 0, 0, 9, 0);
        #2 chk("t6_pop_hz", pend_hazard, 1);
        chk("t6_pop_rd", rf_rd, 9);
        step(0, 0, 0, 0, 0, 0, 9, 0);
        #2 chk("t6_clear_hz", pend_hazard, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end
endmodule
